// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and its memory.
// One request in flight at a time; responses return in order with no back-pressure.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word-aligned fetch at a time and
// fills the IF/ID register, honouring hazard stalls and branch/jump redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_stage_if.master       imem,
  output logic                if_id_valid,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_instruction
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        w_buf_load;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        w_ifid_load;
  logic [31:0] w_ifid_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic        w_accept;

  assign w_tgt    = redirect_pc & ~32'h0000_0003;
  assign w_pc_inc = r_pc + 32'd4;
  assign w_accept = (r_state == S_REQ) && imem.imem_req_ready;

  assign imem.imem_req_valid = (r_state == S_REQ);
  assign imem.imem_req_addr  = r_pc;

  assign if_id_valid       = r_ifid_valid;
  assign if_id_pc          = r_ifid_pc;
  assign if_id_instruction = r_ifid_instr;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_kill_nxt       = r_kill;
    w_buf_load       = 1'b0;
    w_ifid_load      = 1'b0;
    w_ifid_pc_nxt    = r_pc;
    w_ifid_instr_nxt = imem.imem_resp_data;
    case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect_valid;
        end
        if (redirect_valid) w_pc_nxt = w_tgt;
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          // A killed fetch already has pc pointing at the redirect target.
          if (r_kill || redirect_valid) begin
            w_state_nxt = S_REQ;
            if (redirect_valid) w_pc_nxt = w_tgt;
          end else begin
            w_pc_nxt = w_pc_inc;
            if (stall) begin
              w_buf_load  = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_ifid_load = 1'b1;
              w_state_nxt = S_REQ;
            end
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
          w_pc_nxt   = w_tgt;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_ifid_load      = 1'b1;
          w_ifid_pc_nxt    = r_buf_pc;
          w_ifid_instr_nxt = r_buf_instr;
          w_state_nxt      = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_buf_pc     <= '0;
      r_buf_instr  <= NOP;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_buf_load) begin
        r_buf_pc    <= r_pc;
        r_buf_instr <= imem.imem_resp_data;
      end
      // IF/ID priority: redirect flush, then stall hold, then load, else bubble.
      if (redirect_valid) begin
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        if (w_ifid_load) begin
          r_ifid_valid <= 1'b1;
          r_ifid_pc    <= w_ifid_pc_nxt;
          r_ifid_instr <= w_ifid_instr_nxt;
        end else begin
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_only_in_wait: assert (!(imem.imem_resp_valid && (r_state != S_WAIT)));
    end
  end

endmodule
